// File: rtl/xor3_selftest_seq_pkg.sv
// xor3_selftest_seq_pkg: shared types and sizes for the xor3 fabric self-test sequencer
package xor3_selftest_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NUM_PATTERNS = 8;
   localparam int PATTERN_W = 3;
   localparam int ERR_W = 8;
endpackage

// File: rtl/xor3_selftest_seq_result_accum.sv
// xor3_result_accum: saturating mismatch counter, per-pattern fail map and first-fail capture
module xor3_result_accum
   import xor3_selftest_seq_pkg::*;
(
   input  logic                    gclk,
   input  logic                    resetn,
   input  logic                    clear,
   input  logic                    sample_en,
   input  logic                    mismatch,
   input  logic [PATTERN_W-1:0]    pattern,
   output logic [ERR_W-1:0]        err_count,
   output logic [NUM_PATTERNS-1:0] fail_vector,
   output logic [PATTERN_W-1:0]    first_fail
);
   always_ff @(posedge gclk or negedge resetn)
      if (!resetn) begin
         err_count   <= '0;
         fail_vector <= '0;
         first_fail  <= '0;
      end else if (clear) begin
         err_count   <= '0;
         fail_vector <= '0;
         first_fail  <= '0;
      end else if (sample_en && mismatch) begin
         err_count           <= &err_count ? err_count : err_count + 1'b1;
         fail_vector[pattern] <= 1'b1;
         if (err_count == '0) first_fail <= pattern;
      end
endmodule

// File: rtl/xor3_selftest_seq.sv
// xor3_selftest_seq: sweeps all 3-bit patterns into the xor3 DUT and checks its output against odd parity
module xor3_selftest_seq
   import xor3_selftest_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1
) (
   input  logic                    gclk,
   input  logic                    resetn,
   input  logic                    start,
   output logic [PATTERN_W-1:0]    pattern_out,
   input  logic                    dut_result,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ERR_W-1:0]        err_count,
   output logic [NUM_PATTERNS-1:0] fail_vector,
   output logic [PATTERN_W-1:0]    first_fail
);
   localparam int HW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE_CYCLES - 1);
   if (SETTLE_CYCLES < 1 || NUM_PASSES < 1 || NUM_PASSES > 15) begin : g_bad_param
      $error("xor3_selftest_seq: SETTLE_CYCLES must be >= 1 and NUM_PASSES in 1..15");
   end
   state_t        state;
   logic [HW-1:0] hold;
   logic [3:0]    pass_cnt;
   logic          pass_q;
   logic          accept;
   logic          sample;
   logic          mismatch;
   logic          last;
   assign accept   = start && state != RUN;
   assign sample   = state == RUN && hold == HOLD_LAST;
   assign mismatch = dut_result != ^pattern_out;
   assign last     = pattern_out == PATTERN_W'(NUM_PATTERNS - 1) && pass_cnt == 4'(NUM_PASSES - 1);
   assign busy     = state == RUN;
   assign done     = state == DONE;
   assign pass     = pass_q;
   always_ff @(posedge gclk or negedge resetn)
      if (!resetn) begin
         state       <= IDLE;
         pattern_out <= '0;
         hold        <= '0;
         pass_cnt    <= '0;
         pass_q      <= 1'b0;
      end else if (accept) begin
         state       <= RUN;
         pattern_out <= '0;
         hold        <= '0;
         pass_cnt    <= '0;
         pass_q      <= 1'b0;
      end else if (state == RUN) begin
         hold <= sample ? '0 : hold + 1'b1;
         if (sample) begin
            pattern_out <= pattern_out + 1'b1;
            if (pattern_out == PATTERN_W'(NUM_PATTERNS - 1)) pass_cnt <= pass_cnt + 1'b1;
            // the final sample's mismatch is not yet in err_count, so fold it in here
            if (last) begin
               state  <= DONE;
               pass_q <= err_count == '0 && !mismatch;
            end
         end
      end
   xor3_result_accum u_accum (
      .gclk        (gclk),
      .resetn      (resetn),
      .clear       (accept),
      .sample_en   (sample),
      .mismatch    (mismatch),
      .pattern     (pattern_out),
      .err_count   (err_count),
      .fail_vector (fail_vector),
      .first_fail  (first_fail)
   );
endmodule
